// File: rtl/axis_ramp_generator.sv
// axis_ramp_generator: AXI4-Stream ramp source (free-run, wrap, one-shot).
// Ports: aclk/areset, enable, cfg_* in; m_axis_* out; sts_done, sts_wraps.
// Define AXIS_RAMP_GENERATOR_TLAST_EN for packet framing on m_axis_tlast.
module axis_ramp_generator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int PKT_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [1:0]                  cfg_mode,
  input  logic [CNTR_WIDTH-1:0]       cfg_start,
  input  logic [CNTR_WIDTH-1:0]       cfg_step,
  input  logic [CNTR_WIDTH-1:0]       cfg_limit,
  input  logic [PKT_WIDTH-1:0]        cfg_pkt_len,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        sts_done,
  output logic [31:0]                 sts_wraps
);
  localparam int CW = CNTR_WIDTH;
  localparam logic [1:0] M_WRAP = 2'b01;
  localparam logic [1:0] M_ONE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] start_q;
  logic [CW-1:0] step_q;
  logic [CW-1:0] limit_q;
  logic [1:0]    mode_q;
  logic          vld_q;
  logic          done_q;
  logic [31:0]   wraps_q;

  logic          hs;
  logic          over;
  logic          fin;
  logic          ld;
  logic          adv;
  logic          stop;
  logic [CW:0]   sum;
  logic [CW-1:0] nxt;

  assign hs   = vld_q & m_axis_tready;
  assign sum  = {1'b0, cnt_q} + {1'b0, step_q};
  assign over = sum > {1'b0, limit_q};
  assign fin  = (mode_q == M_ONE) && over;
  assign nxt  = (mode_q == M_WRAP && over) ? start_q : sum[CW-1:0];

  // ld: accept a start; adv: move to next beat; stop: leave RUN
  assign ld   = (state_q == IDLE) && enable;
  assign adv  = (state_q == RUN) && hs && !fin && enable;
  assign stop = (state_q == RUN) && hs && !adv;

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (stop) state_d = fin ? DONE : IDLE;
      DONE:    if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q   <= '0;
      start_q <= '0;
      step_q  <= '0;
      limit_q <= '0;
      mode_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      if (ld) begin
        cnt_q   <= cfg_start;
        start_q <= cfg_start;
        step_q  <= cfg_step;
        limit_q <= cfg_limit;
        mode_q  <= (cfg_mode == 2'b11) ? 2'b00 : cfg_mode;
        wraps_q <= '0;
        vld_q   <= 1'b1;
        done_q  <= 1'b0;
      end
      if (adv) begin
        cnt_q <= nxt;
        if (mode_q == M_WRAP && over) wraps_q <= wraps_q + 32'd1;
      end
      if (stop) begin
        vld_q  <= 1'b0;
        done_q <= fin;
      end
      if (state_q == DONE && !enable) done_q <= 1'b0;
    end
  end

  generate
    if (AXIS_TDATA_WIDTH > CW) begin : g_ext
      assign m_axis_tdata = {{(AXIS_TDATA_WIDTH-CW){1'b0}}, cnt_q};
    end else begin : g_trunc
      assign m_axis_tdata = cnt_q[AXIS_TDATA_WIDTH-1:0];
    end
  endgenerate

  assign m_axis_tvalid = vld_q;
  assign sts_done      = done_q;
  assign sts_wraps     = wraps_q;

`ifdef AXIS_RAMP_GENERATOR_TLAST_EN
  logic [PKT_WIDTH-1:0] len_q;
  logic [PKT_WIDTH-1:0] pkt_q;
  logic [PKT_WIDTH-1:0] pkt_n;
  logic                 last_q;
  logic                 pkt_end;
  logic                 fin_ld;
  logic                 fin_nx;
  logic [CW:0]          sum_ld;
  logic [CW:0]          sum_nx;

  assign pkt_end = (len_q != '0) && (pkt_q == len_q - PKT_WIDTH'(1));
  assign pkt_n   = pkt_end ? '0 : pkt_q + PKT_WIDTH'(1);

  // One-shot finality is judged one beat ahead so tlast can be a flop
  assign sum_ld = {1'b0, cfg_start} + {1'b0, cfg_step};
  assign fin_ld = (cfg_mode == M_ONE) && (sum_ld > {1'b0, cfg_limit});
  assign sum_nx = {1'b0, nxt} + {1'b0, step_q};
  assign fin_nx = (mode_q == M_ONE) && (sum_nx > {1'b0, limit_q});

  always_ff @(posedge aclk) begin
    if (areset) begin
      len_q  <= '0;
      pkt_q  <= '0;
      last_q <= 1'b0;
    end else if (ld) begin
      len_q  <= cfg_pkt_len;
      pkt_q  <= '0;
      last_q <= fin_ld || (cfg_pkt_len == PKT_WIDTH'(1));
    end else if (adv) begin
      pkt_q  <= pkt_n;
      last_q <= fin_nx ||
                (len_q != '0 && pkt_n == len_q - PKT_WIDTH'(1));
    end else if (stop) begin
      last_q <= 1'b0;
    end
  end

  assign m_axis_tlast = last_q;
`else
  logic unused_pkt_len;
  assign unused_pkt_len = ^cfg_pkt_len;
  assign m_axis_tlast   = 1'b0;
`endif
endmodule

// File: tb/tb_axis_ramp_generator.sv
// tb_axis_ramp_generator: randomized scoreboard bench for the ramp source.
// Reference model builds the expected beat list from the mode rules.
module tb_axis_ramp_generator;
`ifdef AXIS_RAMP_GENERATOR_TLAST_EN
  localparam bit TL = 1'b1;
`else
  localparam bit TL = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_start;
  logic [31:0] cfg_step;
  logic [31:0] cfg_limit;
  logic [15:0] cfg_pkt_len;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        sts_done;
  logic [31:0] sts_wraps;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [31:0] w;
  } beat_t;

  beat_t q[$];
  int vec = 0;
  int miss = 0;
  int hs_cnt = 0;

  always #5 aclk = ~aclk;

  axis_ramp_generator dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .cfg_mode      (cfg_mode),
    .cfg_start     (cfg_start),
    .cfg_step      (cfg_step),
    .cfg_limit     (cfg_limit),
    .cfg_pkt_len   (cfg_pkt_len),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .sts_done      (sts_done),
    .sts_wraps     (sts_wraps)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected stream: beat i carries its value, tlast on beat index
  // (i mod pkt_len) == pkt_len-1 or on the final one-shot beat.
  task automatic model(input logic [1:0] mode, input logic [31:0] st,
                       input logic [31:0] sp, input logic [31:0] lim,
                       input logic [15:0] pl, input int nmax,
                       output int n, output bit fin);
    logic [31:0] v;
    logic [31:0] w;
    logic [32:0] s;
    logic [1:0]  m;
    beat_t       b;
    v = st;
    w = 0;
    m = (mode == 2'b11) ? 2'b00 : mode;
    n = 0;
    fin = 1'b0;
    for (int i = 0; i < nmax && !fin; i++) begin
      s = {1'b0, v} + {1'b0, sp};
      fin = (m == 2'b10) && (s > {1'b0, lim});
      b.d = v;
      b.w = w;
      b.l = TL && (fin || (pl != 0 && (i % pl) == pl - 1));
      q.push_back(b);
      n++;
      if (m == 2'b01 && s > {1'b0, lim}) begin
        v = st;
        w++;
      end else begin
        v = s[31:0];
      end
    end
  endtask

  task automatic run(input logic [1:0] mode, input logic [31:0] st,
                     input logic [31:0] sp, input logic [31:0] lim,
                     input logic [15:0] pl, input int nmax,
                     input int rdy, input bit stall_end);
    int n;
    int base;
    int cyc;
    bit fin;
    bit r;
    model(mode, st, sp, lim, pl, nmax, n, fin);
    base = hs_cnt;
    cyc = 0;
    cfg_mode = mode;
    cfg_start = st;
    cfg_step = sp;
    cfg_limit = lim;
    cfg_pkt_len = pl;
    enable = 1'b1;
    while (hs_cnt - base < n && cyc < 2000) begin
      r = ($urandom_range(99) < rdy);
      if (!fin && tvalid && r && hs_cnt - base == n - 1) begin
        enable = 1'b0;
        if (stall_end) begin
          tready = 1'b0;
          repeat (5) begin
            @(posedge aclk); #1;
            chk("hold_valid", tvalid, 1);
          end
        end
      end
      tready = r;
      @(posedge aclk); #1;
      cyc++;
    end
    chk("beats_done", hs_cnt - base, n);
    if (hs_cnt - base < n) q.delete();
    tready = 1'b0;
    if (rdy >= 100 && !stall_end) chk("throughput_cycles", cyc, n + 1);
    chk("valid_drop", tvalid, 0);
    if (fin) begin
      chk("done_set", sts_done, 1);
      enable = 1'b0;
      @(posedge aclk); #1;
      chk("done_clr", sts_done, 0);
    end else begin
      chk("done_low", sts_done, 0);
    end
    enable = 1'b0;
    @(posedge aclk); #1;
  endtask

  initial begin
    bit          stall;
    logic [31:0] pd;
    logic        pl;
    beat_t       e;
    logic [1:0]  rm;
    logic [31:0] rs;
    logic [31:0] rp;
    logic [31:0] rl;
    stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    areset = 1'b1;
    enable = 1'b0;
    tready = 1'b0;
    cfg_mode = '0;
    cfg_start = '0;
    cfg_step = '0;
    cfg_limit = '0;
    cfg_pkt_len = '0;

    fork
      forever begin
        @(negedge aclk);
        if (areset) begin
          stall = 1'b0;
        end else begin
          if (stall) begin
            chk("stall_valid", tvalid, 1);
            chk("stall_data", tdata, pd);
            chk("stall_last", tlast, pl);
          end
          if (tvalid && tready) begin
            if (q.size() == 0) begin
              vec++;
              miss++;
              $display("FAIL extra_beat: got tdata %h, expected none", tdata);
            end else begin
              e = q.pop_front();
              chk("tdata", tdata, e.d);
              chk("tlast", tlast, e.l);
              chk("sts_wraps", sts_wraps, e.w);
            end
            hs_cnt++;
          end
          stall = tvalid && !tready;
          pd = tdata;
          pl = tlast;
        end
      end
    join_none

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_valid", tvalid, 0);
    chk("rst_data", tdata, 0);
    chk("rst_last", tlast, 0);
    chk("rst_done", sts_done, 0);
    chk("rst_wraps", sts_wraps, 0);
    areset = 1'b0;
    @(posedge aclk); #1;

    run(2'b00, 32'hFFFF_FFFE, 1, 0, 0, 6, 100, 0);
    run(2'b01, 10, 3, 20, 0, 12, 100, 0);
    run(2'b10, 0, 4, 10, 0, 50, 100, 0);
    run(2'b01, 10, 3, 20, 0, 40, 50, 0);
    run(2'b00, 0, 1, 0, 4, 14, 100, 0);
    run(2'b11, 32'hFFFF_FFF0, 7, 5, 3, 20, 60, 0);
    run(2'b10, 30, 1, 20, 2, 10, 100, 0);
    run(2'b01, 30, 2, 20, 0, 5, 100, 0);
    run(2'b01, 7, 0, 20, 3, 8, 70, 0);
    run(2'b10, 100, 9, 150, 0, 20, 40, 0);
    run(2'b00, 100, 5, 0, 0, 6, 100, 1);

    for (int k = 0; k < 6; k++) begin
      rm = 2'($urandom_range(3));
      rs = $urandom_range(500);
      rp = $urandom_range(40);
      rl = (k == 2) ? rs - 1 : rs + $urandom_range(200);
      run(rm, rs, rp, rl, 16'($urandom_range(5)), 25,
          int'($urandom_range(100, 40)), 0);
    end

    cfg_mode = 2'b00;
    cfg_start = 55;
    cfg_step = 1;
    cfg_pkt_len = 0;
    tready = 1'b0;
    enable = 1'b1;
    repeat (3) begin
      @(posedge aclk); #1;
    end
    chk("run_valid", tvalid, 1);
    chk("run_data", tdata, 55);
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("midrst_valid", tvalid, 0);
    chk("midrst_data", tdata, 0);
    chk("midrst_last", tlast, 0);
    areset = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("idle_valid", tvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
